// File: rtl/iob_uart_rx_pkg.sv
// rtl/iob_uart_rx_pkg.sv - shared types and constants for the UART receiver core
package iob_uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must hold values 0..n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_uart_rx_core_if.sv
// rtl/iob_uart_rx_core_if.sv - line/config inputs and received-word outputs of the UART receiver
interface iob_uart_rx_core_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
);

  logic              en_i;
  logic [DIV_W-1:0]  div_i;
  logic              rxd_i;
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic              frame_err_o;
  logic              busy_o;

  modport master (
    output en_i, div_i, rxd_i,
    input  data_o, data_valid_o, frame_err_o, busy_o
  );

  modport slave (
    input  en_i, div_i, rxd_i,
    output data_o, data_valid_o, frame_err_o, busy_o
  );

endinterface

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - multi-flop synchroniser with clock enable and configurable reset value
module iob_sync
  import iob_uart_rx_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic cke_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sr <= {STAGES{RST_VAL}};
    end else if (cke_i) begin
      if (rst_i) begin
        sr <= {STAGES{RST_VAL}};
      end else begin
        sr <= {sr[STAGES-2:0], d};
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/iob_uart_rx_core.sv
// rtl/iob_uart_rx_core.sv - 8N1-style UART receiver: start-bit detect, mid-bit sampling, framing check
module iob_uart_rx_core
  import iob_uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  iob_uart_rx_core_if.slave rx
);

  localparam int BCNT_W = cnt_w(DATA_W + 1);

  rx_state_t         state, state_nxt;
  logic              rxd_s;
  logic [DIV_W-1:0]  div_q, div_q_nxt;
  logic [DIV_W-1:0]  baud_cnt, baud_nxt;
  logic [BCNT_W-1:0] bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              ferr_q, ferr_nxt;
  logic              baud_zero;

  iob_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rxd_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .d      (rx.rxd_i),
    .q      (rxd_s)
  );

  assign baud_zero = (baud_cnt == '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= IDLE;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state    <= IDLE;
        div_q    <= '0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
        data_q   <= '0;
        valid_q  <= 1'b0;
        ferr_q   <= 1'b0;
      end else begin
        state    <= state_nxt;
        div_q    <= div_q_nxt;
        baud_cnt <= baud_nxt;
        bit_cnt  <= bit_nxt;
        shreg    <= shreg_nxt;
        data_q   <= data_nxt;
        valid_q  <= valid_nxt;
        ferr_q   <= ferr_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    div_q_nxt = div_q;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    // Dropping the enable abandons any frame in flight without touching data_o
    if (!rx.en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            div_q_nxt = rx.div_i;
            baud_nxt  = (rx.div_i >> 1) - DIV_W'(1);
            state_nxt = START;
          end
        end
        START: begin
          if (!baud_zero) begin
            baud_nxt = baud_cnt - DIV_W'(1);
          end else if (rxd_s) begin
            state_nxt = IDLE;
          end else begin
            baud_nxt  = div_q - DIV_W'(1);
            bit_nxt   = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (!baud_zero) begin
            baud_nxt = baud_cnt - DIV_W'(1);
          end else begin
            shreg_nxt = {rxd_s, shreg[DATA_W-1:1]};
            baud_nxt  = div_q - DIV_W'(1);
            bit_nxt   = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(DATA_W - 1)) begin
              state_nxt = STOP;
            end
          end
        end
        STOP: begin
          if (!baud_zero) begin
            baud_nxt = baud_cnt - DIV_W'(1);
          end else if (rxd_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
        BREAK: begin
          // A line held low after a bad stop bit must not look like a new start bit
          if (rxd_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign rx.data_o       = data_q;
  assign rx.data_valid_o = valid_q;
  assign rx.frame_err_o  = ferr_q;
  assign rx.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_iob_uart_rx_core.sv
// tb/tb_iob_uart_rx_core.sv - directed self-checking bench for iob_uart_rx_core
module tb_iob_uart_rx_core;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  logic cke  = 1'b1;
  logic rst  = 1'b0;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  iob_uart_rx_core_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) rx_if ();

  iob_uart_rx_core #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .cke_i  (cke),
    .rst_i  (rst),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] rx_q[$];
  int                rx_cyc[$];
  int                ferr_cnt = 0;
  int                vhigh    = 0;
  logic              prev_v   = 1'b0;
  logic              prev_f   = 1'b0;

  always @(negedge clk) begin
    if (rx_if.data_valid_o && !prev_v) begin
      rx_q.push_back(rx_if.data_o);
      rx_cyc.push_back(cyc);
    end
    if (rx_if.frame_err_o && !prev_f) ferr_cnt <= ferr_cnt + 1;
    if (rx_if.data_valid_o) vhigh <= vhigh + 1;
    if (rx_if.data_valid_o || rx_if.frame_err_o)
      check("valid_ferr_excl", 32'(rx_if.data_valid_o & rx_if.frame_err_o), 32'd0);
    prev_v <= rx_if.data_valid_o;
    prev_f <= rx_if.frame_err_o;
  end

  int fall_cyc = 0;

  task automatic drive_bit(input logic b, input int n);
    rx_if.rxd_i = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input int per, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0, per);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i], per);
    drive_bit(stop, per);
  endtask

  task automatic clear_q();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  logic [DATA_W-1:0] b2b_exp [3] = '{8'h00, 8'hFF, 8'h3C};
  logic [31:0]       snap;
  int                v0, f0, k;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rx_if.en_i  = 1'b1;
    rx_if.div_i = 16'd16;
    rx_if.rxd_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(rx_if.data_o), 32'h0);
    check("rst_valid", 32'(rx_if.data_valid_o), 32'h0);
    check("rst_ferr",  32'(rx_if.frame_err_o), 32'h0);
    check("rst_busy",  32'(rx_if.busy_o), 32'h0);
    arst = 1'b0;
    drive_bit(1'b1, 4);

    // Basic frame, with div_i disturbed mid-frame
    v0 = vhigh;
    fork
      send_frame(8'hA5, 16, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        rx_if.div_i = 16'd5;
        repeat (100) @(posedge clk);
        #1;
        rx_if.div_i = 16'd16;
      end
    join
    drive_bit(1'b1, 4);
    check("basic_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      check("basic_data", 32'(rx_q[0]), 32'hA5);
      check("basic_latency", 32'(rx_cyc[0] - fall_cyc), 32'd155);
    end
    check("basic_width", 32'(vhigh - v0), 32'd1);
    check("basic_ferr", 32'(ferr_cnt), 32'd0);
    clear_q();

    // Back-to-back frames at div 8
    rx_if.div_i = 16'd8;
    drive_bit(1'b1, 2);
    send_frame(8'h00, 8, 1'b1);
    send_frame(8'hFF, 8, 1'b1);
    send_frame(8'h3C, 8, 1'b1);
    drive_bit(1'b1, 8);
    check("b2b_cnt", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > i) check($sformatf("b2b_data%0d", i), 32'(rx_q[i]), 32'(b2b_exp[i]));
    if (rx_q.size() == 3) begin
      check("b2b_gap01", 32'(rx_cyc[1] - rx_cyc[0]), 32'd80);
      check("b2b_gap12", 32'(rx_cyc[2] - rx_cyc[1]), 32'd80);
    end
    clear_q();

    // Glitch rejection
    rx_if.div_i = 16'd16;
    f0 = ferr_cnt;
    drive_bit(1'b0, 3);
    rx_if.rxd_i = 1'b1;
    check("glitch_busy_hi", 32'(rx_if.busy_o), 32'd1);
    k = 0;
    while (rx_if.busy_o && k < 12) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("glitch_busy_lo", 32'(rx_if.busy_o), 32'd0);
    check("glitch_settle", 32'(3 + k), 32'd11);
    drive_bit(1'b1, 20);
    check("glitch_nostrobe", 32'(rx_q.size()), 32'd0);
    check("glitch_noferr", 32'(ferr_cnt - f0), 32'd0);

    // Framing error, held-low line, then recovery
    f0 = ferr_cnt;
    send_frame(8'h55, 16, 1'b0);
    drive_bit(1'b0, 40);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_nostrobe", 32'(rx_q.size()), 32'd0);
    check("ferr_break_busy", 32'(rx_if.busy_o), 32'd1);
    check("ferr_data_hold", 32'(rx_if.data_o), 32'h3C);
    drive_bit(1'b1, 16);
    check("ferr_idle", 32'(rx_if.busy_o), 32'd0);
    send_frame(8'h12, 16, 1'b1);
    drive_bit(1'b1, 8);
    check("ferr_rec_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("ferr_rec_data", 32'(rx_q[0]), 32'h12);
    clear_q();

    // Clock-enable stall: line period 32 clk, div 16 enabled cycles
    fork
      begin
        send_frame(8'hC3, 32, 1'b1);
        drive_bit(1'b1, 8);
      end
      begin
        for (int i = 0; i < 164; i++) begin
          cke = 1'b1;
          @(posedge clk);
          #1;
          cke = 1'b0;
          snap = {21'd0, rx_if.busy_o, rx_if.data_valid_o, rx_if.frame_err_o, rx_if.data_o};
          @(posedge clk);
          #1;
          check("cke_hold", {21'd0, rx_if.busy_o, rx_if.data_valid_o, rx_if.frame_err_o, rx_if.data_o}, snap);
        end
        cke = 1'b1;
      end
    join
    check("cke_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("cke_data", 32'(rx_q[0]), 32'hC3);
    clear_q();

    // Enable dropped at bit 4
    fork
      send_frame(8'h81, 16, 1'b1);
      begin
        repeat (16 + 4 * 16 + 8) @(posedge clk);
        #1;
        rx_if.en_i = 1'b0;
      end
    join
    drive_bit(1'b1, 8);
    check("abort_busy", 32'(rx_if.busy_o), 32'd0);
    check("abort_nostrobe", 32'(rx_q.size()), 32'd0);
    check("abort_data_hold", 32'(rx_if.data_o), 32'hC3);
    rx_if.en_i = 1'b1;
    drive_bit(1'b1, 4);
    send_frame(8'h7E, 16, 1'b1);
    drive_bit(1'b1, 8);
    check("reen_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("reen_data", 32'(rx_q[0]), 32'h7E);
    clear_q();

    // Synchronous soft reset mid-frame
    fork
      send_frame(8'h3C, 16, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        check("srst_busy_pre", 32'(rx_if.busy_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("srst_busy", 32'(rx_if.busy_o), 32'd0);
        check("srst_data", 32'(rx_if.data_o), 32'h0);
        repeat (110) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    drive_bit(1'b1, 8);
    check("srst_nostrobe", 32'(rx_q.size()), 32'd0);
    send_frame(8'h5A, 16, 1'b1);
    drive_bit(1'b1, 8);
    check("post_srst_data", 32'(rx_if.data_o), 32'h5A);
    clear_q();

    // Asynchronous reset mid-frame
    fork
      send_frame(8'hA5, 16, 1'b1);
      begin
        repeat (50) @(posedge clk);
        check("arst_busy_pre", 32'(rx_if.busy_o), 32'd1);
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_data",  32'(rx_if.data_o), 32'h0);
        check("arst_valid", 32'(rx_if.data_valid_o), 32'h0);
        check("arst_ferr",  32'(rx_if.frame_err_o), 32'h0);
        check("arst_busy",  32'(rx_if.busy_o), 32'h0);
      end
    join
    @(negedge clk);
    arst = 1'b0;
    drive_bit(1'b1, 4);
    check("arst_nostrobe", 32'(rx_q.size()), 32'd0);
    check("arst_idle", 32'(rx_if.busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
